enc_top: RTL and testbench



---
 rtl/enc_top.sv | 137 +++++++++++++
 tb/tb_enc_top.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_top.sv
// SM4 block-encryption engine: key expansion and cipher rounds run in lockstep,
// one round per clock, 32 rounds per block, ciphertext presented with a one-cycle valid.
module enc_top (
  input  logic         clk,
  input  logic         rstn,
  input  logic [127:0] data,
  input  logic [127:0] mk,
  input  logic         startenc,
  output logic [127:0] dataout,
  output logic         valid,
  output logic         busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
  endfunction

  // CK byte j of round i is (4i+j)*7 mod 256; the 8-bit product wraps naturally.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    logic [7:0]  idx;
    w = 32'h0;
    for (int j = 0; j < 4; j++) begin
      idx = {1'b0, i, 2'(j)};
      w[31 - 8*j -: 8] = idx * 8'd7;
    end
    return w;
  endfunction

  state_t       r_state;
  logic [4:0]   r_i;
  logic [31:0]  r_x0, r_x1, r_x2, r_x3;
  logic [31:0]  r_k0, r_k1, r_k2, r_k3;
  logic [127:0] r_dataout;
  logic         r_valid;
  logic         r_busy;

  logic [31:0]  w_ck, w_kb, w_rk, w_xb, w_xnew;
  logic [127:0] w_kin;

  assign dataout = r_dataout;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign w_kin   = mk ^ FK;

  // One round of key expansion feeding one cipher round in the same cycle.
  always_comb begin
    w_ck   = ck_word(r_i);
    w_kb   = tau(r_k1 ^ r_k2 ^ r_k3 ^ w_ck);
    w_rk   = r_k0 ^ w_kb ^ rol32(w_kb, 13) ^ rol32(w_kb, 23);
    w_xb   = tau(r_x1 ^ r_x2 ^ r_x3 ^ w_rk);
    w_xnew = r_x0 ^ w_xb ^ rol32(w_xb, 2) ^ rol32(w_xb, 10) ^ rol32(w_xb, 18) ^ rol32(w_xb, 24);
  end

  // Control FSM, round shift registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_i       <= 5'd0;
      r_x0      <= 32'h0;
      r_x1      <= 32'h0;
      r_x2      <= 32'h0;
      r_x3      <= 32'h0;
      r_k0      <= 32'h0;
      r_k1      <= 32'h0;
      r_k2      <= 32'h0;
      r_k3      <= 32'h0;
      r_dataout <= 128'h0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          if (startenc) begin
            {r_x0, r_x1, r_x2, r_x3} <= data;
            {r_k0, r_k1, r_k2, r_k3} <= w_kin;
            r_i     <= 5'd0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          {r_x0, r_x1, r_x2, r_x3} <= {r_x1, r_x2, r_x3, w_xnew};
          {r_k0, r_k1, r_k2, r_k3} <= {r_k1, r_k2, r_k3, w_rk};
          if (r_i == 5'd31) begin
            // Output is the final state in reverse word order: X35, X34, X33, X32.
            r_dataout <= {w_xnew, r_x3, r_x2, r_x1};
            r_valid   <= 1'b1;
            r_busy    <= 1'b0;
            r_i       <= 5'd0;
            r_state   <= S_IDLE;
          end else begin
            r_valid <= 1'b0;
            r_i     <= r_i + 5'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_top.sv
// Self-checking bench for enc_top: scoreboard of expected ciphertexts checked
// against an independent SM4 software model and the published standard vector.
module tb_enc_top;

  logic         clk;
  logic         rstn;
  logic [127:0] data;
  logic [127:0] mk;
  logic         startenc;
  logic [127:0] dataout;
  logic         valid;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] STD_PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT = 128'h681edf34d206965e86b3e94f536e4246;

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  enc_top dut (
    .clk      (clk),
    .rstn     (rstn),
    .data     (data),
    .mk       (mk),
    .startenc (startenc),
    .dataout  (dataout),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] a);
    return {SB[a[31:24]], SB[a[23:16]], SB[a[15:8]], SB[a[7:0]]};
  endfunction

  // Software-style SM4: full key schedule first, then 32 rounds (reversed keys to decrypt).
  function automatic logic [127:0] sm4_model(input logic [127:0] blk, input logic [127:0] key, input bit decrypt);
    logic [127:0] fk;
    logic [31:0]  k[36];
    logic [31:0]  x[36];
    logic [31:0]  t, ck, r;
    fk = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ fk[127 - 32*i -: 32];
      x[i] = blk[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      ck = 32'h0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'((4*i + j) * 7)};
      t = m_sub(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ t ^ m_rol(t, 13) ^ m_rol(t, 23);
    end
    for (int i = 0; i < 32; i++) begin
      r = decrypt ? k[35 - i] : k[i + 4];
      t = m_sub(x[i+1] ^ x[i+2] ^ x[i+3] ^ r);
      x[i+4] = x[i] ^ t ^ m_rol(t, 2) ^ m_rol(t, 10) ^ m_rol(t, 18) ^ m_rol(t, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic start_block(input logic [127:0] d, input logic [127:0] k, input bit push, input logic [127:0] exp);
    @(negedge clk);
    startenc = 1'b1;
    data     = d;
    mk       = k;
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    startenc = 1'b0;
    data     = 128'h0;
    mk       = 128'h0;
  endtask

  // Advances cycle by cycle until valid; lat is edges since the start edge (-1 on timeout).
  task automatic run_to_valid(input bit restart, input bit chain, output int lat, output int busy_cnt, output int hold_bad);
    logic [127:0] held;
    bit done;
    held = dataout;
    lat = -1;
    busy_cnt = 0;
    hold_bad = 0;
    done = 1'b0;
    for (int n = 0; n <= 40 && !done; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == 1) begin
        startenc = 1'b0;
        data = 128'h0;
        mk = 128'h0;
      end
      if (restart && n == 10) begin
        startenc = 1'b1;
        data = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;
        mk = STD_PT;
      end
      if (restart && n == 11) begin
        startenc = 1'b0;
        data = 128'h0;
        mk = 128'h0;
      end
      if (n > 0 && valid === 1'b1) begin
        lat = n;
        done = 1'b1;
        if (chain) begin
          startenc = 1'b1;
          data = 128'h0;
          mk = 128'h0;
        end
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (dataout !== held) hold_bad++;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    startenc = 1'b0;
    data = 128'h0;
    mk = 128'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (dataout !== 128'h0) begin n_bad++; $display("FAIL reset_dataout: got %h want 0", dataout); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_standard;
    int lat, bc, hb;
    logic [127:0] exp;
    start_block(STD_PT, STD_PT, 1'b1, STD_CT);
    run_to_valid(1'b0, 1'b0, lat, bc, hb);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL std_latency: got %0d want 32", lat); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL std_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL std_busy_in_valid: got %b want 0", busy); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL std_scoreboard: got empty queue want entry"); end
    else begin
      exp = sb.pop_front();
      if (dataout !== exp) begin n_bad++; $display("FAIL std_dataout: got %h want %h", dataout, exp); end
    end
    // Round trip: the produced ciphertext must decrypt back to the plaintext.
    exp = sm4_model(dataout, STD_PT, 1'b1);
    n_cmp++; if (exp !== STD_PT) begin n_bad++; $display("FAIL round_trip: got %h want %h", exp, STD_PT); end
    @(posedge clk);
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL std_valid_pulse: got %b want 0", valid); end
  endtask

  task automatic test_ignored_restart;
    int lat, bc, hb, extra;
    logic [127:0] exp;
    start_block(STD_PT, STD_PT, 1'b1, STD_CT);
    run_to_valid(1'b1, 1'b0, lat, bc, hb);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL restart_latency: got %0d want 32", lat); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL restart_scoreboard: got empty queue want entry"); end
    else begin
      exp = sb.pop_front();
      if (dataout !== exp) begin n_bad++; $display("FAIL restart_dataout: got %h want %h", dataout, exp); end
    end
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL restart_extra_valid: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, hb;
    logic [127:0] d, k, exp;
    d = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    start_block(d, k, 1'b1, sm4_model(d, k, 1'b0));
    run_to_valid(1'b0, 1'b1, lat, bc, hb);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 32", lat); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_first_scoreboard: got empty queue want entry"); end
    else begin
      exp = sb.pop_front();
      if (dataout !== exp) begin n_bad++; $display("FAIL b2b_first_dataout: got %h want %h", dataout, exp); end
    end
    sb.push_back(sm4_model(128'h0, 128'h0, 1'b0));
    run_to_valid(1'b0, 1'b0, lat, bc, hb);
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 33", lat); end
    n_cmp++; if (bc !== 32) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 32", bc); end
    n_cmp++; if (hb !== 0) begin n_bad++; $display("FAIL b2b_first_hold: got %0d changes want 0", hb); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_second_scoreboard: got empty queue want entry"); end
    else begin
      exp = sb.pop_front();
      if (dataout !== exp) begin n_bad++; $display("FAIL b2b_second_dataout: got %h want %h", dataout, exp); end
    end
  endtask

  task automatic test_idle_hold;
    logic [127:0] held;
    int bad_d, bad_v, bad_b;
    @(posedge clk);
    #1;
    held = dataout;
    bad_d = 0; bad_v = 0; bad_b = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (dataout !== held) bad_d++;
      if (valid !== 1'b0) bad_v++;
      if (busy !== 1'b0) bad_b++;
    end
    n_cmp++; if (bad_d !== 0) begin n_bad++; $display("FAIL idle_dataout_hold: got %0d changes want 0", bad_d); end
    n_cmp++; if (bad_v !== 0) begin n_bad++; $display("FAIL idle_valid: got %0d high cycles want 0", bad_v); end
    n_cmp++; if (bad_b !== 0) begin n_bad++; $display("FAIL idle_busy: got %0d high cycles want 0", bad_b); end
  endtask

  task automatic test_reset_midrun;
    int lat, bc, hb, extra;
    logic [127:0] exp;
    start_block(STD_PT, STD_PT, 1'b0, 128'h0);
    repeat (20) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_cmp++; if (dataout !== 128'h0) begin n_bad++; $display("FAIL midrst_dataout: got %h want 0", dataout); end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL midrst_no_valid: got %0d pulses want 0", extra); end
    start_block(STD_PT, STD_PT, 1'b1, STD_CT);
    run_to_valid(1'b0, 1'b0, lat, bc, hb);
    n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d want 32", lat); end
    n_cmp++;
    if (sb.size() == 0) begin n_bad++; $display("FAIL midrst_scoreboard: got empty queue want entry"); end
    else begin
      exp = sb.pop_front();
      if (dataout !== exp) begin n_bad++; $display("FAIL midrst_dataout: got %h want %h", dataout, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_standard();
    test_ignored_restart();
    test_back_to_back();
    test_idle_hold();
    test_reset_midrun();
    n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
